alu_rr_arbiter: RTL and testbench

- Shares the single combinational ALU (op1/op2/alu_sel in; alu_out, zero, carry, overflow out) between two requesters.
- Round-robin arbitration with valid/ready handshakes on both the request and response sides.
- Sequences one operation at a time through a 3-state FSM and registers the result and flags.
- Sits between the execute-stage issuers (ch0 = main pipe, ch1 = auxiliary unit) and the ALU instance.

---
 rtl/alu_rr_arbiter.sv | 173 +++++++++++++++++
 tb/tb_alu_rr_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: shares one combinational ALU between two issuers
// with round-robin grant and valid/ready request/response handshakes.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   req{0,1}_*          request channel: valid/ready, op1, op2, sel
//   rsp{0,1}_valid/rdy  response handshake per channel
//   rsp_result, rsp_*   registered ALU result and flags (shared)
//   alu_*               to/from the external combinational ALU
//   busy                high while an operation is in EXEC or RESP
module alu_rr_arbiter #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_op1,
    input  logic [WIDTH-1:0] req0_op2,
    input  logic [SEL_W-1:0] req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_op1,
    input  logic [WIDTH-1:0] req1_op2,
    input  logic [SEL_W-1:0] req1_sel,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_carry,
    output logic             rsp_overflow,
    output logic [WIDTH-1:0] alu_op1,
    output logic [WIDTH-1:0] alu_op2,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] op1_q, op1_d;
    logic [WIDTH-1:0] op2_q, op2_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             v0_q, v0_d;
    logic             v1_q, v1_d;
    logic             busy_q, busy_d;
    logic             gnt0, gnt1;
    logic             rsp_hs;

    // last_q==1 means ch1 was served last, so ch0 wins a tie.
    always_comb begin
        gnt1 = req1_valid && (!req0_valid || !last_q);
        gnt0 = req0_valid && !gnt1;
    end

    assign req0_ready = (state_q == IDLE) && gnt0;
    assign req1_ready = (state_q == IDLE) && gnt1;
    assign rsp_hs     = id_q ? rsp1_ready : rsp0_ready;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        sel_d   = sel_q;
        res_d   = res_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        v0_d    = v0_q;
        v1_d    = v1_q;
        busy_d  = busy_q;
        unique case (state_q)
            IDLE: begin
                if (gnt0 || gnt1) begin
                    op1_d   = gnt1 ? req1_op1 : req0_op1;
                    op2_d   = gnt1 ? req1_op2 : req0_op2;
                    sel_d   = gnt1 ? req1_sel : req0_sel;
                    id_d    = gnt1;
                    last_d  = gnt1;
                    state_d = EXEC;
                    busy_d  = 1'b1;
                end
            end
            EXEC: begin
                res_d   = alu_out;
                zero_d  = alu_zero;
                carry_d = alu_carry;
                ovf_d   = alu_overflow;
                v0_d    = !id_q;
                v1_d    = id_q;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_hs) begin
                    v0_d    = 1'b0;
                    v1_d    = 1'b0;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                v0_d    = 1'b0;
                v1_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            op1_q   <= '0;
            op2_q   <= '0;
            sel_q   <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            v0_q    <= 1'b0;
            v1_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            sel_q   <= sel_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            busy_q  <= busy_d;
        end
    end

    // ALU inputs simply hold the last latched operation.
    assign alu_op1      = op1_q;
    assign alu_op2      = op2_q;
    assign alu_sel      = sel_q;
    assign rsp0_valid   = v0_q;
    assign rsp1_valid   = v1_q;
    assign rsp_result   = res_q;
    assign rsp_zero     = zero_q;
    assign rsp_carry    = carry_q;
    assign rsp_overflow = ovf_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb_alu_rr_arbiter: directed plus random transactions against a
// transaction-level model of round-robin grant and ALU results.
module tb_alu_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready;
    logic [31:0] req0_op1, req0_op2;
    logic [3:0]  req0_sel;
    logic        req1_valid, req1_ready;
    logic [31:0] req1_op1, req1_op2;
    logic [3:0]  req1_sel;
    logic        rsp0_valid, rsp0_ready;
    logic        rsp1_valid, rsp1_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero, rsp_carry, rsp_overflow;
    logic [31:0] alu_op1, alu_op2, alu_out;
    logic [3:0]  alu_sel;
    logic        alu_zero, alu_carry, alu_overflow;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    int last_g = 1;

    always #5 clk = ~clk;

    alu_rr_arbiter #(.WIDTH(32), .SEL_W(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_op1(req0_op1), .req0_op2(req0_op2),
        .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_op1(req1_op1), .req1_op2(req1_op2),
        .req1_sel(req1_sel),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .rsp_carry(rsp_carry), .rsp_overflow(rsp_overflow),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_zero(alu_zero),
        .alu_carry(alu_carry), .alu_overflow(alu_overflow),
        .busy(busy)
    );

    // {overflow, carry, zero, result}
    function automatic logic [34:0] alu_f(
        input logic [3:0] s, input logic [31:0] a,
        input logic [31:0] b);
        logic [32:0] t;
        logic [31:0] r;
        logic        c, o;
        r = '0; c = 1'b0; o = 1'b0;
        case (s)
            4'd0: begin
                t = {1'b0, a} + {1'b0, b};
                r = t[31:0];
                c = t[32];
                o = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'd1: begin
                r = a - b;
                c = (a < b);
                o = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'd2:  r = a | b;
            4'd3:  r = a ^ b;
            4'd4:  r = a & b;
            4'd5:  r = {31'b0, $signed(a) < $signed(b)};
            4'd8:  r = a << b[4:0];
            4'd9:  r = a >> b[4:0];
            4'd10: r = $signed(a) >>> b[4:0];
            default: r = '0;
        endcase
        return {o, c, (r == 32'd0), r};
    endfunction

    always_comb
        {alu_overflow, alu_carry, alu_zero, alu_out} =
            alu_f(alu_sel, alu_op1, alu_op2);

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_inputs();
        req0_valid = 0; req1_valid = 0;
        rsp0_ready = 0; rsp1_ready = 0;
    endtask

    // One full transaction; the ungranted channel keeps its request up
    // until the response completes to prove it is held off.
    task automatic run_op(
        input bit v0, input bit v1,
        input logic [31:0] a0, input logic [31:0] b0,
        input logic [3:0] s0,
        input logic [31:0] a1, input logic [31:0] b1,
        input logic [3:0] s1, input int hold);
        int          g;
        logic [31:0] ea, eb;
        logic [3:0]  es;
        logic [34:0] exp;
        logic [34:0] first;
        @(posedge clk); #1;
        req0_valid = v0; req0_op1 = a0; req0_op2 = b0; req0_sel = s0;
        req1_valid = v1; req1_op1 = a1; req1_op2 = b1; req1_sel = s1;
        if (v0 && v1) g = (last_g == 0) ? 1 : 0;
        else g = v1 ? 1 : 0;
        ea  = g ? a1 : a0;
        eb  = g ? b1 : b0;
        es  = g ? s1 : s0;
        exp = alu_f(es, ea, eb);
        @(negedge clk);
        check("req0_ready", 64'(req0_ready), 64'(g == 0));
        check("req1_ready", 64'(req1_ready), 64'(g == 1));
        @(posedge clk); #1;
        last_g = g;
        if (g == 0) req0_valid = 0;
        else req1_valid = 0;
        @(negedge clk);
        check("exec_busy", 64'(busy), 64'd1);
        check("exec_ops", {alu_op1, alu_op2}, {ea, eb});
        check("exec_sel", 64'(alu_sel), 64'(es));
        check("exec_rv", {rsp0_valid, rsp1_valid}, 64'd0);
        check("exec_qr", {req0_ready, req1_ready}, 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rsp_valid", {rsp0_valid, rsp1_valid},
              (g == 0) ? 64'd2 : 64'd1);
        check("rsp_data",
              64'({rsp_overflow, rsp_carry, rsp_zero, rsp_result}),
              64'(exp));
        check("rsp_sel_hold", 64'(alu_sel), 64'(es));
        first = {rsp_overflow, rsp_carry, rsp_zero, rsp_result};
        // Ready on the idle response channel must be ignored.
        if (g == 0) rsp1_ready = 1;
        else rsp0_ready = 1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("hold_valid", {rsp0_valid, rsp1_valid},
                  (g == 0) ? 64'd2 : 64'd1);
            check("hold_data",
                  64'({rsp_overflow, rsp_carry, rsp_zero,
                       rsp_result}), 64'(first));
            check("hold_busy", 64'(busy), 64'd1);
            check("hold_qr", {req0_ready, req1_ready}, 64'd0);
        end
        rsp0_ready = 1; rsp1_ready = 1;
        @(posedge clk); #1;
        @(negedge clk);
        check("done_valid", {rsp0_valid, rsp1_valid}, 64'd0);
        check("done_busy", 64'(busy), 64'd0);
        clr_inputs();
    endtask

    logic [3:0] sels [9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
                             4'd5, 4'd8, 4'd9, 4'd10};

    initial begin
        clr_inputs();
        req0_op1 = 0; req0_op2 = 0; req0_sel = 0;
        req1_op1 = 0; req1_op2 = 0; req1_sel = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("rst_valid", {rsp0_valid, rsp1_valid}, 64'd0);
        check("rst_res", 64'(rsp_result), 64'd0);
        check("rst_flags",
              {rsp_zero, rsp_carry, rsp_overflow}, 64'd0);
        check("rst_alu", {alu_op1, alu_op2}, 64'd0);
        check("rst_sel", 64'(alu_sel), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_qr", {req0_ready, req1_ready}, 64'd0);
        last_g = 1;

        run_op(1, 0, 32'h10, 32'h20, 4'd0, 0, 0, 0, 0);
        check("add_res", 64'(rsp_result), 64'h30);

        run_op(1, 1, 32'h20, 32'h10, 4'd1,
               32'hF0F0F0F0, 32'h0F0F0F0F, 4'd4, 0);
        run_op(1, 1, 32'h20, 32'h10, 4'd1,
               32'hF0F0F0F0, 32'h0F0F0F0F, 4'd4, 0);
        run_op(1, 1, 32'h5, 32'h7, 4'd3,
               32'h1, 32'h2, 4'd2, 1);

        run_op(0, 1, 0, 0, 0, 32'h7FFFFFFF, 32'h1, 4'd0, 5);
        run_op(1, 0, 32'h80000000, 32'h1, 4'd10, 0, 0, 0, 0);

        // Reset while an op is in EXEC.
        @(posedge clk); #1;
        req0_valid = 1; req0_op1 = 32'h3; req0_op2 = 32'h4;
        req0_sel = 4'd0;
        @(posedge clk); #1;
        req0_valid = 0;
        @(negedge clk);
        check("mid_busy", 64'(busy), 64'd1);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check("mid_valid", {rsp0_valid, rsp1_valid}, 64'd0);
        check("mid_busy0", 64'(busy), 64'd0);
        check("mid_sel", 64'(alu_sel), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_novalid", {rsp0_valid, rsp1_valid}, 64'd0);
        last_g = 1;
        run_op(0, 1, 0, 0, 0, 32'h9, 32'h9, 4'd1, 0);
        run_op(1, 1, 32'h1, 32'h1, 4'd0, 32'h2, 32'h2, 4'd0, 0);
        last_g = 1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        run_op(1, 1, 32'hA, 32'h1, 4'd0, 32'hB, 32'h1, 4'd0, 0);

        for (int i = 0; i < 60; i++) begin
            int k;
            k = int'($urandom_range(0, 3));
            if (k == 0) begin
                @(posedge clk); #1;
                clr_inputs();
                @(negedge clk);
                check("idle_qr", {req0_ready, req1_ready}, 64'd0);
                check("idle_busy", 64'(busy), 64'd0);
            end else begin
                run_op(k[0], k[1],
                       $urandom, $urandom,
                       sels[$urandom_range(0, 8)],
                       $urandom, $urandom,
                       sels[$urandom_range(0, 8)],
                       int'($urandom_range(0, 3)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
